// File: rtl/alu_logic_arbiter.sv
// Two-requester round-robin front end for a shared WIDTH-bit AND/OR/NOR/XOR unit.
// Optional macro ALU_ARB_STATS_EN adds saturating per-requester accept counters.
module alu_logic_arbiter #(
  parameter int WIDTH      = 4,
  parameter int OP_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOR = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam logic [3:0] EXEC_LAST = 4'(OP_LATENCY - 1);

  state_t           state;
  logic             last_grant;
  logic [3:0]       exec_cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] result;

  // On contention the requester that did not win last time gets the grant.
  assign grant0 = (state == ST_IDLE) && req0_valid && (!req1_valid || last_grant);
  assign grant1 = (state == ST_IDLE) && req1_valid && (!req0_valid || !last_grant);
  assign accept = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Only the granted requester's fields reach the operand registers.
  always_comb begin
    sel_op = req0_op;
    sel_a  = req0_a;
    sel_b  = req0_b;
    if (grant1) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end
  end

  always_comb begin
    result = '0;
    case (op_q)
      OP_AND:  result = a_q & b_q;
      OP_OR:   result = a_q | b_q;
      OP_NOR:  result = ~(a_q | b_q);
      OP_XOR:  result = a_q ^ b_q;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      exec_cnt   <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            id_q       <= grant1;
            last_grant <= grant1;
            exec_cnt   <= '0;
            busy       <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_cnt == EXEC_LAST) begin
            rsp_y     <= result;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            exec_cnt  <= '0;
            state     <= ST_RESP;
          end else begin
            exec_cnt <= exec_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          // Result and id stay frozen until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0 && (grant_cnt0 != 8'hFF)) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (grant1 && (grant_cnt1 != 8'hFF)) grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule
